// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/execute/commit sequencer owning the instruction pointer.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int unsigned            ADDR_W         = 32,
  parameter int unsigned            INSTR_W        = 32,
  parameter int unsigned            IP_STEP        = 1,
  parameter logic [ADDR_W-1:0]      RESET_ADDR     = '0,
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_busy,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pointer,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pointer_q, pointer_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    state_d   = state_q;
    pointer_d = pointer_q;
    instr_d   = instr_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d    = wait_q;
    fault_d   = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      FETCH: begin
`ifdef FETCH_TIMEOUT_EN
        // The watchdog wins even if the ack lands on the limit cycle.
        if (wait_q == WAIT_LIMIT) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
`else
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
`endif
      end
      EXEC: begin
        if (!exec_busy) begin
          if (halt_req) begin
            state_d = HALT;
          end else begin
            pointer_d = branch_taken ? branch_target : pointer_q + ADDR_W'(IP_STEP);
            state_d   = run ? FETCH : IDLE;
`ifdef FETCH_TIMEOUT_EN
            wait_d    = '0;
`endif
          end
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pointer_q <= RESET_ADDR;
      instr_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_q    <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_d;
      instr_q   <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q    <= wait_d;
      fault_q   <= fault_d;
`endif
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign halted      = (state_q == HALT);
  assign imem_addr   = pointer_q;
  assign pointer     = pointer_q;
  assign instr       = instr_q;

`ifdef FETCH_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (vector table, corner sequences, random vs model).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, imem_ack, exec_busy, halt_req, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, instr_valid, halted, fault;
  logic [31:0] imem_addr, instr, pointer;
  logic        req2, valid2, halted2, fault2;
  logic [31:0] addr2, instr2, ptr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .exec_busy(exec_busy), .halt_req(halt_req), .branch_taken(branch_taken),
    .branch_target(branch_target), .pointer(pointer), .halted(halted), .fault(fault)
  );

  fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset), .run(run), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr2), .instr_valid(valid2),
    .exec_busy(exec_busy), .halt_req(halt_req), .branch_taken(branch_taken),
    .branch_target(branch_target), .pointer(ptr2), .halted(halted2), .fault(fault2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    run = 0; imem_ack = 0; imem_rdata = 0; exec_busy = 0;
    halt_req = 0; branch_taken = 0; branch_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic run, ack; logic [31:0] rdata;
    logic busy, halt, br; logic [31:0] tgt;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_instr; logic e_halted;
  } vec_t;

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic b, logic h, logic br,
                              logic [31:0] t, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic eh);
    vec_t v;
    v.run = r; v.ack = a; v.rdata = d; v.busy = b; v.halt = h; v.br = br; v.tgt = t;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_halted = eh;
    return v;
  endfunction

  localparam logic [31:0] WA = 32'hA5A5_0001, WB = 32'h1234_5678, WC = 32'hDEAD_BEEF;
  localparam logic [31:0] WD = 32'h5555_AAAA, WE = 32'hCAFE_0000;

  // Reference model: one record of where the sequencer is in its instruction life cycle.
  logic [31:0] m_ptr, m_instr;
  logic        m_fetching, m_execing, m_halted, m_fault;
  int          m_wait;

  task automatic model_reset();
    m_ptr = 0; m_instr = 0; m_fetching = 0; m_execing = 0;
    m_halted = 0; m_fault = 0; m_wait = 0;
  endtask

  task automatic model_step();
    if (m_halted) begin
    end else if (m_fetching) begin
`ifdef FETCH_TIMEOUT_EN
      if (m_wait == 15) begin
        m_fetching = 0; m_halted = 1; m_fault = 1;
      end else
`endif
      if (imem_ack) begin
        m_instr = imem_rdata; m_fetching = 0; m_execing = 1;
      end else begin
        m_wait++;
      end
    end else if (m_execing) begin
      if (!exec_busy) begin
        m_execing = 0;
        if (halt_req) m_halted = 1;
        else begin
          m_ptr = branch_taken ? branch_target : m_ptr + 32'd1;
          m_fetching = run; m_wait = 0;
        end
      end
    end else if (run) begin
      m_fetching = 1; m_wait = 0;
    end
  endtask

  vec_t vecs[24];
  int   halt_cycles;

  initial begin
    vecs[0]  = mk(1,0,0 ,0,0,0,0    , 0,32'h00,0,0 ,0);
    vecs[1]  = mk(1,1,WA,0,0,0,0    , 1,32'h00,0,0 ,0);
    vecs[2]  = mk(1,0,0 ,0,0,0,0    , 0,32'h00,1,WA,0);
    vecs[3]  = mk(1,1,WA,0,0,0,0    , 1,32'h01,0,WA,0);
    vecs[4]  = mk(1,0,0 ,0,0,0,0    , 0,32'h01,1,WA,0);
    vecs[5]  = mk(1,1,WA,0,0,0,0    , 1,32'h02,0,WA,0);
    vecs[6]  = mk(1,0,0 ,0,0,0,0    , 0,32'h02,1,WA,0);
    vecs[7]  = mk(1,1,WA,0,0,0,0    , 1,32'h03,0,WA,0);
    vecs[8]  = mk(1,0,0 ,0,0,0,0    , 0,32'h03,1,WA,0);
    vecs[9]  = mk(1,1,WA,0,0,0,0    , 1,32'h04,0,WA,0);
    vecs[10] = mk(1,0,0 ,0,0,0,0    , 0,32'h04,1,WA,0);
    vecs[11] = mk(1,1,WB,0,0,0,0    , 1,32'h05,0,WA,0);
    vecs[12] = mk(1,0,0 ,0,0,1,32'h40,0,32'h05,1,WB,0);
    vecs[13] = mk(0,0,0 ,0,0,0,0    , 1,32'h40,0,WB,0);
    vecs[14] = mk(0,1,WC,0,0,0,0    , 1,32'h40,0,WB,0);
    vecs[15] = mk(0,0,0 ,1,1,1,32'h77,0,32'h40,1,WC,0);
    vecs[16] = mk(0,0,0 ,1,0,0,0    , 0,32'h40,1,WC,0);
    vecs[17] = mk(0,0,0 ,1,0,0,0    , 0,32'h40,1,WC,0);
    vecs[18] = mk(0,0,0 ,0,0,0,0    , 0,32'h40,1,WC,0);
    vecs[19] = mk(0,1,WD,0,0,0,0    , 0,32'h41,0,WC,0);
    vecs[20] = mk(1,0,0 ,0,0,0,0    , 0,32'h41,0,WC,0);
    vecs[21] = mk(1,1,WE,0,0,0,0    , 1,32'h41,0,WC,0);
    vecs[22] = mk(1,0,0 ,0,1,1,32'h99,0,32'h41,1,WE,0);
    vecs[23] = mk(1,1,0 ,0,0,0,0    , 0,32'h41,0,WE,1);

    idle_inputs();
    reset = 1'b1;
    #2;
    chk("async_reset_req", {31'd0, imem_req}, 0);
    chk("async_reset_ptr", pointer, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_ptr", i), pointer, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
      chk($sformatf("v%0d_fault", i), {31'd0, fault}, 0);
      if (i == 0) chk("wrap_reset_ptr", ptr2, 32'hFFFF_FFFF);
      if (i == 3) begin
        chk("wrap_req", {31'd0, req2}, 1);
        chk("wrap_addr", addr2, 0);
      end
      run = vecs[i].run; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      exec_busy = vecs[i].busy; halt_req = vecs[i].halt;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_hold_req", {31'd0, imem_req}, 0);
      chk("halt_hold_halted", {31'd0, halted}, 1);
      chk("halt_hold_ptr", pointer, 32'h41);
    end

    // Reset while a fetch at pointer 1 is outstanding and ack is asserted.
    do_reset();
    run = 1; imem_ack = 1; imem_rdata = WA;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("midfetch_pre_req", {31'd0, imem_req}, 1);
    chk("midfetch_pre_addr", imem_addr, 1);
    #1 reset = 1'b1;
    #1;
    chk("midfetch_req", {31'd0, imem_req}, 0);
    chk("midfetch_ptr", pointer, 0);
    chk("midfetch_valid", {31'd0, instr_valid}, 0);
    chk("midfetch_instr", instr, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    @(negedge clk);
    run = 1;
    @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to_req_%0d", k), {31'd0, imem_req}, 1);
      chk($sformatf("to_fault_%0d", k), {31'd0, fault}, 0);
      imem_ack = (k == 15);
      @(negedge clk);
    end
    chk("to_end_req", {31'd0, imem_req}, 0);
    chk("to_end_fault", {31'd0, fault}, 1);
    chk("to_end_halted", {31'd0, halted}, 1);
    chk("to_end_valid", {31'd0, instr_valid}, 0);
`else
    for (int k = 0; k < 40; k++) begin
      chk("wait_req", {31'd0, imem_req}, 1);
      chk("wait_fault", {31'd0, fault}, 0);
      @(negedge clk);
    end
    imem_ack = 1; imem_rdata = WB;
    @(negedge clk);
    chk("late_ack_valid", {31'd0, instr_valid}, 1);
    chk("late_ack_instr", instr, WB);
`endif

    do_reset();
    model_reset();
    halt_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, m_fetching});
      chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_execing});
      chk("rnd_halted", {31'd0, halted}, {31'd0, m_halted});
      chk("rnd_fault", {31'd0, fault}, {31'd0, m_fault});
      chk("rnd_ptr", pointer, m_ptr);
      chk("rnd_addr", imem_addr, m_ptr);
      chk("rnd_instr", instr, m_instr);
      if (m_halted) halt_cycles++;
      if (halt_cycles > 4) begin
        do_reset();
        model_reset();
        halt_cycles = 0;
      end else begin
        run = ($urandom_range(0, 9) < 8);
        imem_ack = ($urandom_range(0, 9) < 6);
        imem_rdata = $urandom;
        exec_busy = ($urandom_range(0, 9) < 4);
        halt_req = ($urandom_range(0, 19) == 0);
        branch_taken = ($urandom_range(0, 9) < 3);
        branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        model_step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction sequencer for the core; owns the instruction pointer.
- Issues fetch requests to instruction memory over a req/ack handshake and latches the returned word for the decoder.
- Holds the instruction while the execute datapath (ALU, register file) is busy, then commits the next pointer: sequential, branch or halt.
- Replaces the free-running pointer counter as the core's control path.

Parameters:
ADDR_W, 32, width of pointer and fetch address
INSTR_W, 32, instruction word width
IP_STEP, 1, pointer increment per sequential instruction (word addressing)
RESET_ADDR, 0, pointer value after reset
TIMEOUT_CYCLES, 16, fetch watchdog limit; used only with FETCH_TIMEOUT_EN

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; enables fetching of the next instruction
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address; equals pointer while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  INSTR_W  fetched instruction word
instr  out  INSTR_W  latched instruction to decoder
instr_valid  out  1  instr is current and being executed
exec_busy  in  1  execute datapath needs more cycles
halt_req  in  1  decoded halt; sampled at commit
branch_taken  in  1  redirect pointer; sampled at commit
branch_target  in  ADDR_W  redirect address
pointer  out  ADDR_W  current instruction pointer
halted  out  1  sequencer stopped
fault  out  1  fetch timeout; constant 0 without FETCH_TIMEOUT_EN

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. All outputs registered or decoded from state only, except imem_addr (= pointer).
- Reset (async, any state, any cycle):
  - state=IDLE, pointer=RESET_ADDR, instr=0.
  - imem_req=0, instr_valid=0, halted=0, fault=0.
  - Outputs take reset values without waiting for a clock edge.
- IDLE:
  - imem_req=0, instr_valid=0.
  - run=1 -> FETCH next cycle.
  - imem_ack ignored.
- FETCH:
  - imem_req=1, imem_addr=pointer, both held stable until ack.
  - Ack may arrive in the same cycle as the first req cycle (zero-wait memory).
  - On imem_ack=1: instr<=imem_rdata, -> EXEC.
  - run falling during FETCH does not abort the fetch.
- EXEC:
  - instr_valid=1, instr stable.
  - exec_busy=1 -> stay; pointer unchanged.
  - exec_busy=0 -> commit this cycle:
    - halt_req=1: -> HALT, pointer unchanged, halted=1 next cycle.
    - else branch_taken=1: pointer<=branch_target.
    - else pointer<=pointer+IP_STEP, modulo 2^ADDR_W (0xFFFF_FFFF+1 -> 0).
    - Next state after a non-halt commit: run=1 -> FETCH, else IDLE.
  - Priority at commit: halt_req > branch_taken > sequential.
  - halt_req and branch inputs are ignored while exec_busy=1.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - Exit only via reset.
- Throughput: zero-wait memory and exec_busy=0 give 2 cycles/instruction (FETCH, EXEC alternating).
- branch_target is not checked for alignment.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - 8-bit wait counter cleared on entry to FETCH, incremented each FETCH cycle with imem_ack=0.
  - When count reaches TIMEOUT_CYCLES-1 with no ack: drop imem_req next cycle, -> HALT, fault=1 and halted=1.
  - Timeout takes precedence over an ack arriving the cycle after the limit.
  - fault cleared only by reset.
- Undefined: no counter; FETCH waits indefinitely; fault tied to 0.

Test Plan:
1. Reset, run=1, ack same cycle as req, imem_rdata=0xA5A5_0001, exec_busy=0 -> imem_addr 0,1,2,3 on alternate cycles; instr_valid high on alternating cycles; instr=0xA5A5_0001.
2. Branch: EXEC at pointer=5 with branch_taken=1, branch_target=0x40 -> next imem_addr=0x40, pointer=0x40.
3. exec_busy=1 for 3 cycles in EXEC -> instr_valid high 4 cycles; pointer holds until busy drops, then +1.
4. halt_req=1 with branch_taken=1 at commit -> halted=1, pointer unchanged, imem_req stays 0 for 20 cycles despite run=1.
5. Pointer wrap: RESET_ADDR=0xFFFF_FFFF, one sequential commit -> pointer=0x0000_0000, next imem_addr=0.
6. Reset asserted mid-FETCH with ack pending -> imem_req=0, pointer=RESET_ADDR before the next edge. With FETCH_TIMEOUT_EN, no ack for 16 cycles -> fault=1, halted=1.
